// File: rtl/gem_fiber_in_if.sv
// Receive word stream into gem_fiber_in and the decoded frame/status outputs.
// master drives the GTX words and controls; slave is the frame decoder.
interface gem_fiber_in_if;
  logic [31:0] rx_data;
  logic [3:0]  rx_isk;
  logic        err_cnt_rst;
  logic        ena_test_pat;
  logic [55:0] gem_data;
  logic        gem_overflow;
  logic        data_valid;
  logic [1:0]  bxn_lsb;
  logic        locked;
  logic        idle_det;
  logic [15:0] sync_err_cnt;
  logic [15:0] testpat_err_cnt;

  modport master (
    output rx_data, rx_isk, err_cnt_rst, ena_test_pat,
    input  gem_data, gem_overflow, data_valid, bxn_lsb, locked, idle_det,
           sync_err_cnt, testpat_err_cnt
  );

  modport slave (
    input  rx_data, rx_isk, err_cnt_rst, ena_test_pat,
    output gem_data, gem_overflow, data_valid, bxn_lsb, locked, idle_det,
           sync_err_cnt, testpat_err_cnt
  );
endinterface

// File: rtl/gem_fiber_in.sv
// GEM fiber receiver: aligns data/separator word pairs, tracks link lock, counts errors.
// Define GEM_FIBER_IN_TESTPAT_CHECK_EN to build the payload test-pattern checker.
module gem_fiber_in #(
  parameter int unsigned LOCK_CNT   = 8,
  parameter int unsigned UNLOCK_CNT = 4
) (
  input  logic          trg_clk80_i,
  input  logic          trg_rst_i,
  gem_fiber_in_if.slave bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HUNT    = 2'd1;
  localparam logic [1:0] ST_LOCKING = 2'd2;
  localparam logic [1:0] ST_LOCKED  = 2'd3;
  localparam logic [4:0] LOCK_N     = 5'(LOCK_CNT);
  localparam logic [4:0] UNLOCK_N   = 5'(UNLOCK_CNT);

  // Reset asserts at once but releases only after two clock edges.
  logic [1:0] rst_sync_q;
  logic       rst_int;

  always_ff @(posedge trg_clk80_i or posedge trg_rst_i) begin
    if (trg_rst_i) rst_sync_q <= 2'b11;
    else           rst_sync_q <= {rst_sync_q[0], 1'b0};
  end
  assign rst_int = rst_sync_q[1];

  logic [1:0]  state_q, state_d;
  logic        phase_q, phase_d;
  logic        prev_data_q;
  logic [31:0] prev_word_q;
  logic [3:0]  good_cnt_q, good_cnt_d;
  logic [3:0]  bad_cnt_q, bad_cnt_d;
  logic [1:0]  exp_q, exp_d;
  logic [55:0] gem_data_q, gem_data_d;
  logic        ovf_q, ovf_d;
  logic [1:0]  bxn_q, bxn_d;
  logic        dv_q, dv_d;
  logic [15:0] sync_err_q;
  logic        sync_err_inc;

  logic        is_idle, is_data, sep_isk, sep_valid, sep_fc, is_sep, frame_good;
  logic [1:0]  sep_idx, exp_next;

  always_comb begin
    sep_valid = 1'b1;
    sep_fc    = 1'b0;
    sep_idx   = 2'd0;
    case (bus.rx_data[7:0])
      8'hBC:   sep_idx = 2'd0;
      8'hF7:   sep_idx = 2'd1;
      8'hFB:   sep_idx = 2'd2;
      8'hFD:   sep_idx = 2'd3;
      8'hFC:   sep_fc  = 1'b1;
      default: sep_valid = 1'b0;
    endcase
  end

  assign is_idle    = (bus.rx_data == 32'h50BC_50BC) && (bus.rx_isk == 4'b0101);
  assign is_data    = (bus.rx_isk == 4'b0000);
  assign sep_isk    = (bus.rx_isk == 4'b0001);
  assign is_sep     = sep_isk && sep_valid;
  assign frame_good = prev_data_q && is_sep && (sep_fc || (sep_idx == exp_q));
  // FC carries no position of its own, so it only steps the expectation forward.
  assign exp_next   = (is_sep && !sep_fc) ? sep_idx + 2'd1 : exp_q + 2'd1;

  always_comb begin
    state_d      = state_q;
    phase_d      = ~phase_q;
    good_cnt_d   = good_cnt_q;
    bad_cnt_d    = bad_cnt_q;
    exp_d        = exp_q;
    gem_data_d   = gem_data_q;
    ovf_d        = ovf_q;
    bxn_d        = bxn_q;
    dv_d         = 1'b0;
    sync_err_inc = 1'b0;
    if (is_idle) begin
      state_d    = ST_IDLE;
      good_cnt_d = 4'd0;
      bad_cnt_d  = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: if (is_data) state_d = ST_HUNT;
        ST_HUNT: begin
          if (prev_data_q && is_sep) begin
            state_d    = ST_LOCKING;
            good_cnt_d = 4'd1;
            phase_d    = 1'b0;
            exp_d      = exp_next;
          end
        end
        ST_LOCKING: begin
          if (phase_q) begin
            exp_d = exp_next;
            if (!frame_good) begin
              state_d    = ST_HUNT;
              good_cnt_d = 4'd0;
            end else if ({1'b0, good_cnt_q} + 5'd1 >= LOCK_N) begin
              state_d    = ST_LOCKED;
              good_cnt_d = 4'd0;
              bad_cnt_d  = 4'd0;
            end else begin
              good_cnt_d = good_cnt_q + 4'd1;
            end
          end
        end
        default: begin
          if (phase_q) begin
            exp_d = exp_next;
            if (frame_good) begin
              bad_cnt_d  = 4'd0;
              dv_d       = 1'b1;
              gem_data_d = {prev_word_q, bus.rx_data[31:8]};
              ovf_d      = sep_fc;
              if (!sep_fc) bxn_d = sep_idx;
            end else begin
              sync_err_inc = 1'b1;
              if ({1'b0, bad_cnt_q} + 5'd1 >= UNLOCK_N) begin
                state_d   = ST_HUNT;
                bad_cnt_d = 4'd0;
              end else begin
                bad_cnt_d = bad_cnt_q + 4'd1;
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge trg_clk80_i or posedge rst_int) begin
    if (rst_int) begin
      state_q     <= ST_IDLE;
      phase_q     <= 1'b0;
      prev_data_q <= 1'b0;
      prev_word_q <= 32'd0;
      good_cnt_q  <= 4'd0;
      bad_cnt_q   <= 4'd0;
      exp_q       <= 2'd0;
      gem_data_q  <= 56'd0;
      ovf_q       <= 1'b0;
      bxn_q       <= 2'd0;
      dv_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      prev_data_q <= is_data;
      prev_word_q <= bus.rx_data;
      good_cnt_q  <= good_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      exp_q       <= exp_d;
      gem_data_q  <= gem_data_d;
      ovf_q       <= ovf_d;
      bxn_q       <= bxn_d;
      dv_q        <= dv_d;
    end
  end

  always_ff @(posedge trg_clk80_i or posedge rst_int) begin
    if (rst_int)                                  sync_err_q <= 16'd0;
    else if (bus.err_cnt_rst)                     sync_err_q <= 16'd0;
    else if (sync_err_inc && sync_err_q != 16'hFFFF) sync_err_q <= sync_err_q + 16'd1;
  end

`ifdef GEM_FIBER_IN_TESTPAT_CHECK_EN
  logic [15:0] tp_err_q;
  logic        tp_hit;

  // Payload [7:0] and [15:8] sit in separator-word bytes 1 and 2.
  assign tp_hit = dv_d && bus.ena_test_pat && (bus.rx_data[15:8] != bus.rx_data[23:16]);

  always_ff @(posedge trg_clk80_i or posedge rst_int) begin
    if (rst_int)                             tp_err_q <= 16'd0;
    else if (bus.err_cnt_rst)                tp_err_q <= 16'd0;
    else if (tp_hit && tp_err_q != 16'hFFFF) tp_err_q <= tp_err_q + 16'd1;
  end
  assign bus.testpat_err_cnt = tp_err_q;
`else
  logic tp_unused;
  assign tp_unused           = bus.ena_test_pat;
  assign bus.testpat_err_cnt = 16'h0000;
`endif

  assign bus.gem_data     = gem_data_q;
  assign bus.gem_overflow = ovf_q;
  assign bus.bxn_lsb      = bxn_q;
  assign bus.data_valid   = dv_q;
  assign bus.locked       = (state_q == ST_LOCKED);
  assign bus.idle_det     = (state_q == ST_IDLE);
  assign bus.sync_err_cnt = sync_err_q;

endmodule

// File: tb/tb_gem_fiber_in.sv
// Testbench for gem_fiber_in: directed link scenarios plus random word traffic,
// checked every cycle against a frame-level reference model.
module tb_gem_fiber_in;
  localparam int LOCK_CNT   = 8;
  localparam int UNLOCK_CNT = 4;
  localparam logic [31:0] IDLE_W = 32'h50BC_50BC;
  localparam int M_IDLE = 0, M_HUNT = 1, M_LOCKING = 2, M_LOCKED = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gem_fiber_in_if bus();

  gem_fiber_in #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT)) dut (
    .trg_clk80_i(clk),
    .trg_rst_i  (rst),
    .bus        (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int dv_seen  = 0;
  bit cmp_en   = 1'b0;
  int nx       = 0;
  logic [7:0] seq_b [4] = '{8'hBC, 8'hF7, 8'hFB, 8'hFD};

  // Reference model state: link mode, word history and expected outputs.
  int          m_state = M_IDLE, m_good = 0, m_bad = 0, m_exp = 0, m_hold = 0;
  bit          m_prev_data = 1'b0, m_ph = 1'b0;
  logic [31:0] m_prev_word = '0;
  logic [55:0] e_data = '0;
  bit          e_ovf = 1'b0, e_dv = 1'b0;
  logic [1:0]  e_bxn = '0;
  int          e_sync = 0, e_tp = 0;

  function automatic int sep_pos(input logic [7:0] b);
    for (int i = 0; i < 4; i++) if (seq_b[i] == b) return i;
    if (b == 8'hFC) return 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_good = 0; m_bad = 0; m_exp = 0;
    m_prev_data = 1'b0; m_prev_word = '0; m_ph = 1'b0;
    e_data = '0; e_ovf = 1'b0; e_dv = 1'b0; e_bxn = '0; e_sync = 0; e_tp = 0;
  endtask

  task automatic model_step(input logic [31:0] d, input logic [3:0] k, input bit ecr, input bit ena);
    int p;
    bit sepw, good, bad_locked, tp_hit;
    p = sep_pos(d[7:0]);
    sepw = (k == 4'b0001) && (p >= 0);
    e_dv = 1'b0; bad_locked = 1'b0; tp_hit = 1'b0;
    if (d == IDLE_W && k == 4'b0101) begin
      m_state = M_IDLE; m_good = 0; m_bad = 0;
    end else if (m_state == M_IDLE) begin
      if (k == 4'b0000) m_state = M_HUNT;
    end else if (m_state == M_HUNT) begin
      if (m_prev_data && sepw) begin
        m_state = M_LOCKING; m_good = 1; m_ph = 1'b0;
        m_exp = (sepw && p < 4) ? (p + 1) % 4 : (m_exp + 1) % 4;
      end
    end else begin
      if (m_ph) begin
        good = m_prev_data && sepw && (p == 4 || p == m_exp);
        m_exp = (sepw && p < 4) ? (p + 1) % 4 : (m_exp + 1) % 4;
        if (m_state == M_LOCKING) begin
          if (good) begin
            m_good++;
            if (m_good >= LOCK_CNT) begin m_state = M_LOCKED; m_bad = 0; end
          end else begin
            m_state = M_HUNT; m_good = 0;
          end
        end else if (good) begin
          m_bad = 0; e_dv = 1'b1;
          e_data = {m_prev_word, d[31:8]};
          e_ovf = (p == 4);
          if (p != 4) e_bxn = 2'(p);
          tp_hit = ena && (e_data[7:0] != e_data[15:8]);
        end else begin
          bad_locked = 1'b1; m_bad++;
          if (m_bad >= UNLOCK_CNT) begin m_state = M_HUNT; m_bad = 0; end
        end
      end
      m_ph = !m_ph;
    end
    if (ecr) e_sync = 0;
    else if (bad_locked && e_sync < 65535) e_sync++;
`ifdef GEM_FIBER_IN_TESTPAT_CHECK_EN
    if (ecr) e_tp = 0;
    else if (tp_hit && e_tp < 65535) e_tp++;
`else
    if (tp_hit) e_tp = e_tp;
`endif
    m_prev_data = (k == 4'b0000);
    m_prev_word = d;
  endtask

  // Internal reset releases two edges after the pin, so the model holds reset as well.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset(); m_hold = 2;
    end else if (m_hold > 0) begin
      model_reset(); m_hold--;
    end else begin
      model_step(bus.rx_data, bus.rx_isk, bus.err_cnt_rst, bus.ena_test_pat);
    end
  end

  always @(negedge clk) begin
    if (bus.data_valid === 1'b1) dv_seen++;
    if (cmp_en) begin
      n_checks++;
      if (bus.gem_data !== e_data || bus.gem_overflow !== e_ovf || bus.data_valid !== e_dv ||
          bus.bxn_lsb !== e_bxn || bus.locked !== (m_state == M_LOCKED) ||
          bus.idle_det !== (m_state == M_IDLE) || bus.sync_err_cnt !== 16'(e_sync) ||
          bus.testpat_err_cnt !== 16'(e_tp))
        $display("FAIL model_cmp t=%0t got data=%h ovf=%b dv=%b bxn=%0d lk=%b idle=%b se=%0d tp=%0d exp data=%h ovf=%b dv=%b bxn=%0d lk=%b idle=%b se=%0d tp=%0d",
                 $time, bus.gem_data, bus.gem_overflow, bus.data_valid, bus.bxn_lsb, bus.locked,
                 bus.idle_det, bus.sync_err_cnt, bus.testpat_err_cnt, e_data, e_ovf, e_dv, e_bxn,
                 m_state == M_LOCKED, m_state == M_IDLE, e_sync, e_tp);
      else
        n_pass++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic send_word(input logic [31:0] d, input logic [3:0] k);
    bus.rx_data = d; bus.rx_isk = k;
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [55:0] p, input logic [7:0] s,
                            input logic [3:0] kd, input logic [3:0] ks);
    send_word(p[55:24], kd);
    send_word({p[23:0], s}, ks);
  endtask

  task automatic send_good(input logic [55:0] p);
    send_frame(p, seq_b[nx], 4'b0000, 4'b0001);
    nx = (nx + 1) % 4;
  endtask

  localparam logic [55:0] P1 = 56'h01_2345_6789_ABCD;
  localparam logic [55:0] P2 = 56'hA5_5A11_2233_4455;
  localparam logic [55:0] P3 = 56'h00_0000_0000_1234;
  localparam logic [55:0] P4 = 56'h00_0000_0000_5656;

  initial begin
    logic [55:0] pr;
    int r, s;
    bus.rx_data = IDLE_W; bus.rx_isk = 4'b0101;
    bus.err_cnt_rst = 1'b0; bus.ena_test_pat = 1'b0;
    #2 rst = 1'b1;
    #1 cmp_en = 1'b1;
    chk("rst_idle_det", bus.idle_det, 1);
    chk("rst_locked", bus.locked, 0);
    chk("rst_gem_data", bus.gem_data, 0);
    chk("rst_dv", bus.data_valid, 0);
    chk("rst_sync_cnt", bus.sync_err_cnt, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) send_word(IDLE_W, 4'b0101);

    // Lock-up: 10 frames, lock on frame 8, strobes on 9 and 10.
    dv_seen = 0; nx = 0;
    send_word(P1[55:24], 4'b0000);
    chk("idle_det_falls", bus.idle_det, 0);
    send_word({P1[23:0], seq_b[0]}, 4'b0001);
    nx = 1;
    for (int f = 2; f <= 10; f++) begin
      send_good(P1);
      if (f == 7) chk("locked_f7", bus.locked, 0);
      if (f == 8) begin chk("locked_f8", bus.locked, 1); chk("no_dv_f8", bus.data_valid, 0); end
      if (f == 9) begin
        chk("dv_f9", bus.data_valid, 1);
        chk("data_f9", bus.gem_data, 56'h01_2345_6789_ABCD);
        chk("bxn_f9", bus.bxn_lsb, 0);
      end
      if (f == 10) begin chk("dv_f10", bus.data_valid, 1); chk("bxn_f10", bus.bxn_lsb, 1); end
    end

    // FC in place of FB.
    send_word(P2[55:24], 4'b0000);
    chk("dv_count_lock", dv_seen, 2);
    send_word({P2[23:0], 8'hFC}, 4'b0001);
    nx = 3;
    chk("fc_ovf", bus.gem_overflow, 1);
    chk("fc_bxn_hold", bus.bxn_lsb, 1);
    chk("fc_data", bus.gem_data, P2);
    chk("fc_no_err", bus.sync_err_cnt, 0);
    send_good(P1);
    chk("fd_after_fc_dv", bus.data_valid, 1);
    chk("fd_after_fc_ovf", bus.gem_overflow, 0);
    chk("fd_after_fc_bxn", bus.bxn_lsb, 3);

    // Three sequence jumps, one good frame, four bad-K frames.
    send_frame(P1, 8'hFB, 4'b0000, 4'b0001);
    send_frame(P1, 8'hBC, 4'b0000, 4'b0001);
    send_frame(P1, 8'hFD, 4'b0000, 4'b0001);
    chk("jump_sync_cnt", bus.sync_err_cnt, 3);
    nx = 0;
    send_good(P1);
    chk("good_after_jump_dv", bus.data_valid, 1);
    for (int i = 1; i <= 4; i++) begin
      send_frame(P1, seq_b[nx], 4'b0010, 4'b0001);
      nx = (nx + 1) % 4;
      if (i == 3) chk("still_locked_3bad", bus.locked, 1);
    end
    chk("unlock_4bad", bus.locked, 0);
    chk("unlock_sync_cnt", bus.sync_err_cnt, 7);
    chk("unlock_not_idle", bus.idle_det, 0);

    // Relock from HUNT, then idle word mid-frame.
    nx = 0;
    repeat (9) send_good(P2);
    chk("relock_dv", bus.data_valid, 1);
    send_word(P2[55:24], 4'b0000);
    send_word(IDLE_W, 4'b0101);
    chk("idle_mid_idle_det", bus.idle_det, 1);
    chk("idle_mid_locked", bus.locked, 0);
    chk("idle_mid_dv", bus.data_valid, 0);

    // Clear colliding with an error, then test-pattern errors and a clear pulse.
    nx = 0;
    repeat (9) send_good(P1);
    bus.err_cnt_rst = 1'b1;
    send_frame(P1, seq_b[(nx + 2) % 4], 4'b0000, 4'b0001);
    bus.err_cnt_rst = 1'b0;
    nx = (nx + 3) % 4;
    chk("ecr_wins", bus.sync_err_cnt, 0);
    send_frame(P1, seq_b[(nx + 1) % 4], 4'b0000, 4'b0001);
    nx = (nx + 2) % 4;
    chk("err_after_ecr", bus.sync_err_cnt, 1);
    bus.ena_test_pat = 1'b1;
    repeat (5) send_good(P3);
    send_good(P4);
`ifdef GEM_FIBER_IN_TESTPAT_CHECK_EN
    chk("tp_cnt_5", bus.testpat_err_cnt, 5);
`else
    chk("tp_cnt_absent", bus.testpat_err_cnt, 0);
`endif
    bus.err_cnt_rst = 1'b1;
    send_word(P1[55:24], 4'b0000);
    bus.err_cnt_rst = 1'b0;
    send_word({P1[23:0], seq_b[nx]}, 4'b0001);
    nx = (nx + 1) % 4;
    chk("ecr_sync_0", bus.sync_err_cnt, 0);
    chk("ecr_tp_0", bus.testpat_err_cnt, 0);
    bus.ena_test_pat = 1'b0;

    // Reset in the middle of a frame.
    send_word(P2[55:24], 4'b0000);
    #2 rst = 1'b1;
    #1 chk("midrst_dv", bus.data_valid, 0);
    chk("midrst_data", bus.gem_data, 0);
    chk("midrst_idle", bus.idle_det, 1);
    @(posedge clk); #1 rst = 1'b0;
    send_word({P2[23:0], seq_b[nx]}, 4'b0001);
    chk("after_rst_dv", bus.data_valid, 0);
    repeat (3) send_word(IDLE_W, 4'b0101);

    // Random traffic against the model.
    nx = 0;
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      bus.ena_test_pat = 1'($urandom_range(0, 1));
      bus.err_cnt_rst  = ($urandom_range(0, 49) == 0);
      pr = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) pr[15:8] = pr[7:0];
      if (r < 78) send_good(pr);
      else if (r < 83) begin
        s = $urandom_range(0, 3);
        send_frame(pr, seq_b[s], 4'b0000, 4'b0001);
        nx = (s + 1) % 4;
      end else if (r < 86) begin
        send_frame(pr, 8'hFC, 4'b0000, 4'b0001);
        nx = (nx + 1) % 4;
      end else if (r < 90) begin
        send_frame(pr, seq_b[nx], 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        nx = (nx + 1) % 4;
      end else if (r < 92) begin
        send_frame(pr, 8'h3C, 4'b0000, 4'b0001);
        nx = (nx + 1) % 4;
      end else if (r < 95) send_word($urandom, ($urandom_range(0, 1) == 1) ? 4'b0000 : 4'b0001);
      else if (r < 99) send_word(IDLE_W, 4'b0101);
      else begin
        #2 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
      end
    end
    bus.err_cnt_rst = 1'b0;
    repeat (4) send_word(IDLE_W, 4'b0101);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/gem_fiber_in.md
GEM_FIBER_IN -- requirements
Module: gem_fiber_in

Interface
REQ-001 LOCK_CNT, 8: consecutive good frames needed to go from LOCKING to LOCKED (range 2..15).
REQ-002 UNLOCK_CNT, 4: consecutive bad frames needed to go from LOCKED to HUNT (range 1..15).
REQ-003 TRG_CLK80  in  1  80 MHz word clock; the only clock.
REQ-004 TRG_RST  in  1  asynchronous, active-high reset.
REQ-005 RX_DATA  in  32  decoded GTX receive word, sampled on the rising edge of TRG_CLK80.
REQ-006 RX_ISK  in  4  per-byte K-flag for RX_DATA; bit 0 maps to byte [7:0].
REQ-007 ERR_CNT_RST  in  1  synchronous clear of all error counters.
REQ-008 ENA_TEST_PAT  in  1  enables the test-pattern check.
REQ-009 GEM_DATA  out  56  last good frame payload.
REQ-010 GEM_OVERFLOW  out  1  set when the last good frame carried separator FC.
REQ-011 DATA_VALID  out  1  one-cycle strobe marking new GEM_DATA.
REQ-012 BXN_LSB  out  2  separator index: BC=0, F7=1, FB=2, FD=3; holds its previous value on FC.
REQ-013 LOCKED  out  1  high while the FSM is in LOCKED.
REQ-014 IDLE_DET  out  1  high while the FSM is in IDLE.
REQ-015 SYNC_ERR_CNT  out  16  count of bad frames seen in LOCKED; saturates at FFFF.
REQ-016 TESTPAT_ERR_CNT  out  16  count of test-pattern mismatches; saturates at FFFF; present only with the macro.

Function
REQ-017 Word definitions:
- Idle word: RX_DATA = 32'h50BC50BC and RX_ISK = 4'b0101.
- Data word (phase 0): RX_ISK = 4'b0000.
- Separator word (phase 1): RX_ISK = 4'b0001 and byte [7:0] in {BC, F7, FB, FD, FC}.
REQ-018 Frame payload: GEM_DATA = {data_word[31:0], sep_word[31:8]}.
REQ-019 Good frame: a data word immediately followed by a separator word whose separator is FC or equals the expected separator.
REQ-020 Expected separator sequence: BC->F7->FB->FD->BC. After every evaluated frame, expected becomes the successor of the received separator. FC advances expected by one step from the previous expected value.
REQ-021 FSM states: IDLE, HUNT, LOCKING, LOCKED.
REQ-022 Any state, idle word received -> IDLE; good and bad counters are cleared.
REQ-023 IDLE: first word with RX_ISK = 0000 -> HUNT; that word is captured as the phase-0 word.
REQ-024 HUNT: a separator word directly after a data word -> LOCKING with good_cnt = 1; expected is set from that separator and its sequence value is not checked.
REQ-025 LOCKING: each good frame increments good_cnt; good_cnt reaching LOCK_CNT -> LOCKED. Any bad frame -> HUNT.
REQ-026 LOCKED: the phase toggles every cycle and a frame is evaluated on every phase-1 word. Bad frame conditions: wrong RX_ISK in either word, invalid separator byte, or sequence mismatch. Each bad frame increments bad_cnt and SYNC_ERR_CNT; bad_cnt reaching UNLOCK_CNT -> HUNT. A good frame clears bad_cnt.
REQ-027 Output update: on a good frame in LOCKED, the outputs update at the clock edge that samples the separator word. GEM_DATA, GEM_OVERFLOW and BXN_LSB are registered there, and DATA_VALID is high for exactly the following cycle. No DATA_VALID is produced in any other state or on a bad frame.
REQ-028 Output hold: GEM_DATA, GEM_OVERFLOW and BXN_LSB hold their values between DATA_VALID strobes.
REQ-029 The frame that completes LOCKING -> LOCKED does not produce DATA_VALID; the first DATA_VALID comes from the next good frame.
REQ-030 ERR_CNT_RST together with an error in the same cycle: the clear wins and the counter reads 0.
REQ-031 Counters saturate at FFFF and never wrap.

Reset
REQ-032 TRG_RST asynchronously forces:
- FSM = IDLE;
- GEM_DATA = 0, GEM_OVERFLOW = 0, DATA_VALID = 0, BXN_LSB = 0, LOCKED = 0, IDLE_DET = 1;
- all counters = 0;
- expected separator = BC.
REQ-033 Reset asserted mid-frame discards the partial frame; no DATA_VALID is produced during or immediately after reset.
REQ-034 Reset deassertion is synchronized to TRG_CLK80 inside the block.

Configuration
REQ-035 The macro GEM_FIBER_IN_TESTPAT_CHECK_EN controls the test-pattern check.
- Defined: on each good frame in LOCKED with ENA_TEST_PAT = 1, payload [7:0] is compared with payload [15:8]; a mismatch increments TESTPAT_ERR_CNT.
- Not defined: the check logic is absent and TESTPAT_ERR_CNT is tied to 0.

Verification
REQ-036 Reset release, then 3 idle words, then 10 frames with separators BC,F7,FB,FD,... and payload 56'h0123456789ABCD -> IDLE_DET falls on the first data word; LOCKED rises after 8 good frames; DATA_VALID fires on frames 9 and 10 with that payload.
REQ-037 While LOCKED, send a frame with separator FC in place of FB -> GEM_OVERFLOW = 1, BXN_LSB unchanged, no error; the next FD is accepted.
REQ-038 While LOCKED, send 3 frames with sequence jumps, then 1 good frame, then 4 frames with bad RX_ISK -> SYNC_ERR_CNT = 7; LOCKED drops after the 4th consecutive bad frame; FSM = HUNT.
REQ-039 While LOCKED, send an idle word mid-frame -> IDLE_DET = 1 and LOCKED = 0 on the next cycle, with no DATA_VALID.
REQ-040 With the macro defined and ENA_TEST_PAT = 1, send 5 frames with payload [7:0] != [15:8] -> TESTPAT_ERR_CNT = 5; then pulse ERR_CNT_RST -> both counters read 0.
